ddr_frame_writer: RTL and testbench

Parametrised successor to the render-side DDR2 write-port controller. It takes a stream of 32-bit pixel words, pushes them into one MIG user write port, and packs them into bursts of up to BURST_LEN words. It issues one write command per burst and cycles through NUM_FRAMES frame buffers, publishing the last completed buffer to the read side. It adds two modes: a hardware frame-clear fill, and a restart that rewinds to the start of the current frame.

---
 rtl/ddr_frame_writer.sv | 218 +++++++++++++++++++++
 tb/tb_ddr_frame_writer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer: packs a 32-bit pixel stream into bursts on one MIG user
// write port, issues one write command per burst, and rotates through
// NUM_FRAMES frame buffers. Supports a hardware frame clear and a restart
// that rewinds to the start of the current frame.
module ddr_frame_writer #(
  parameter int unsigned BURST_LEN    = 32,
  parameter int unsigned FRAME_WORDS  = 921600,
  parameter int unsigned NUM_FRAMES   = 2,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned FRAME_STRIDE = 4194304,
  parameter logic [31:0] CLEAR_VALUE  = 32'h0,
  parameter int unsigned ADDR_W       = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_calib_done,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear_req,
  input  logic              restart,
  input  logic              wr_full,
  output logic              wr_en,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_mask,
  input  logic              cmd_full,
  output logic              cmd_en,
  output logic [2:0]        cmd_instr,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W-1:0] cmd_byte_addr,
  output logic [2:0]        write_frame,
  output logic [2:0]        display_frame,
  output logic              frame_done,
  output logic              busy
);

  localparam int OFF_W = $clog2(FRAME_WORDS + 1);
  localparam int BC_W  = $clog2(BURST_LEN + 1);
  localparam logic [OFF_W-1:0] FRAME_END  = OFF_W'(FRAME_WORDS);
  localparam logic [BC_W-1:0]  BURST_END  = BC_W'(BURST_LEN);
  localparam logic [2:0]       LAST_FRAME = 3'(NUM_FRAMES - 1);

  typedef enum logic [2:0] {
    S_WAIT_CAL, S_IDLE, S_FILL, S_CMD, S_SWAP, S_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [OFF_W-1:0]  bstart_q, bstart_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              clearing_q, clearing_d;
  logic              clr_pend_q, clr_pend_d;
  logic              rst_pend_q, rst_pend_d;
  logic [2:0]        write_frame_q, write_frame_d;
  logic [2:0]        display_frame_q, display_frame_d;
  logic              frame_done_q, busy_q;
  logic [5:0]        cmd_bl_q;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;

  logic fill_st, accept, clr_push, clr_ignore, cmd_load;

  // Handshake and write-FIFO push are combinational so a word lands in the FIFO
  // on the same cycle it is accepted; a pending clear/restart blocks new input.
  assign fill_st    = (state_q == S_IDLE) || (state_q == S_FILL);
  assign in_ready   = fill_st && !wr_full && (bcnt_q < BURST_END) && !clr_pend_q && !rst_pend_q;
  assign accept     = in_ready && in_valid;
  assign clr_push   = (state_q == S_CLEAR) && !wr_full && (bcnt_q < BURST_END);
  assign wr_en      = accept || clr_push;
  assign wr_data    = clr_push ? CLEAR_VALUE : (accept ? in_data : 32'h0);
  assign wr_mask    = 4'b0000;
  assign cmd_en     = (state_q == S_CMD) && !cmd_full;
  assign cmd_instr  = 3'b000;
  assign cmd_bl     = cmd_bl_q;
  assign cmd_byte_addr = cmd_addr_q;
  assign write_frame   = write_frame_q;
  assign display_frame = display_frame_q;
  assign frame_done    = frame_done_q;
  assign busy          = busy_q;

  // A clear in progress swallows further clear/restart requests.
  assign clr_ignore = (state_q == S_CLEAR) || ((state_q == S_CMD) && clearing_q);
  // Command fields are latched once, on entry to CMD, and held while cmd_full stalls.
  assign cmd_load   = (state_d == S_CMD) && (state_q != S_CMD);
  assign cmd_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(write_frame_q) * ADDR_W'(FRAME_STRIDE)
                    + ADDR_W'({bstart_q, 2'b00});

  // Next-state logic for the burst/frame controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d         = state_q;
    off_d           = off_q;
    bcnt_d          = bcnt_q;
    bstart_d        = bstart_q;
    clearing_d      = clearing_q;
    write_frame_d   = write_frame_q;
    display_frame_d = display_frame_q;
    clr_pend_d      = clr_pend_q || (clear_req && !clr_ignore);
    rst_pend_d      = (rst_pend_q || (restart && !clr_ignore)) && !clr_pend_d;

    unique case (state_q)
      S_WAIT_CAL: if (mem_calib_done) state_d = S_IDLE;

      S_IDLE, S_FILL: begin
        if (clr_pend_q || rst_pend_q) begin
          if (bcnt_q != '0) begin
            state_d = S_CMD;                       // flush the partial burst first
          end else begin
            off_d      = '0;
            bstart_d   = '0;
            rst_pend_d = 1'b0;
            if (clr_pend_q) begin
              clr_pend_d = 1'b0;
              clearing_d = 1'b1;
              state_d    = S_CLEAR;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (accept) begin
          off_d   = off_q + OFF_W'(1);
          bcnt_d  = bcnt_q + BC_W'(1);
          state_d = (bcnt_d == BURST_END || off_d == FRAME_END) ? S_CMD : S_FILL;
        end
      end

      S_CMD: if (!cmd_full) begin
        bcnt_d   = '0;
        bstart_d = off_q;
        if (off_q == FRAME_END) begin
          if (clearing_q) begin
            off_d      = '0;
            bstart_d   = '0;
            clearing_d = 1'b0;
            state_d    = S_IDLE;                   // cleared frame stays the write frame
          end else begin
            state_d = S_SWAP;
          end
        end else if (clearing_q) begin
          state_d = S_CLEAR;
        end else if (clr_pend_q) begin
          off_d      = '0;
          bstart_d   = '0;
          clr_pend_d = 1'b0;
          rst_pend_d = 1'b0;
          clearing_d = 1'b1;
          state_d    = S_CLEAR;
        end else if (rst_pend_q) begin
          off_d      = '0;
          bstart_d   = '0;
          rst_pend_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_FILL;
        end
      end

      S_SWAP: begin
        display_frame_d = write_frame_q;
        write_frame_d   = (write_frame_q == LAST_FRAME) ? 3'd0 : write_frame_q + 3'd1;
        off_d           = '0;
        bstart_d        = '0;
        rst_pend_d      = 1'b0;                    // new frame already starts at 0
        if (clr_pend_q) begin
          clr_pend_d = 1'b0;
          clearing_d = 1'b1;
          state_d    = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: if (clr_push) begin
        off_d  = off_q + OFF_W'(1);
        bcnt_d = bcnt_q + BC_W'(1);
        if (bcnt_d == BURST_END || off_d == FRAME_END) state_d = S_CMD;
      end

      default: state_d = S_WAIT_CAL;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_WAIT_CAL;
      off_q           <= '0;
      bstart_q        <= '0;
      bcnt_q          <= '0;
      clearing_q      <= 1'b0;
      clr_pend_q      <= 1'b0;
      rst_pend_q      <= 1'b0;
      write_frame_q   <= 3'd0;
      display_frame_q <= LAST_FRAME;
      frame_done_q    <= 1'b0;
      busy_q          <= 1'b0;
      cmd_bl_q        <= '0;
      cmd_addr_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q         <= state_d;
      off_q           <= off_d;
      bstart_q        <= bstart_d;
      bcnt_q          <= bcnt_d;
      clearing_q      <= clearing_d;
      clr_pend_q      <= clr_pend_d;
      rst_pend_q      <= rst_pend_d;
      write_frame_q   <= write_frame_d;
      display_frame_q <= display_frame_d;
      frame_done_q    <= (state_d == S_SWAP);
      busy_q          <= (state_d != S_IDLE);
      if (cmd_load) begin
        cmd_bl_q   <= 6'(bcnt_d - BC_W'(1));
        cmd_addr_q <= cmd_addr_d;
      end
    end
  end

endmodule

// File: tb/tb_ddr_frame_writer.sv
// tb_ddr_frame_writer: directed scenarios for ddr_frame_writer with a
// queue-based scoreboard; the monitor pops expected writes/commands whenever
// the DUT pushes to the MIG write or command FIFO.
module tb_ddr_frame_writer;

  localparam int unsigned BL     = 4;
  localparam int unsigned FW     = 10;
  localparam int unsigned NF     = 3;
  localparam int unsigned BASE   = 32'h100;
  localparam int unsigned STRIDE = 32'h40;
  localparam int unsigned AW     = 30;
  localparam logic [31:0] CLR    = 32'hC1EA_0C1E;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [5:0]    bl;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_calib_done = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          clear_req = 1'b0;
  logic          restart = 1'b0;
  logic          wr_full = 1'b0;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;
  logic          cmd_full = 1'b0;
  logic          cmd_en;
  logic [2:0]    cmd_instr;
  logic [5:0]    cmd_bl;
  logic [AW-1:0] cmd_byte_addr;
  logic [2:0]    write_frame;
  logic [2:0]    display_frame;
  logic          frame_done;
  logic          busy;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  logic [31:0] exp_wr[$];
  cmd_t        exp_cmd[$];

  ddr_frame_writer #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .NUM_FRAMES(NF), .BASE_ADDR(BASE),
    .FRAME_STRIDE(STRIDE), .CLEAR_VALUE(CLR), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clear_req(clear_req), .restart(restart),
    .wr_full(wr_full), .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
    .cmd_full(cmd_full), .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .write_frame(write_frame),
    .display_frame(display_frame), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [AW-1:0] addr, input logic [5:0] bl);
    cmd_t c;
    c.addr = addr;
    c.bl   = bl;
    exp_cmd.push_back(c);
  endtask

  // Three bursts of a 10-word frame: 4 + 4 + 2 words.
  task automatic push_frame_cmds(input logic [AW-1:0] base);
    push_cmd(base,          6'd3);
    push_cmd(base + 'h10,   6'd3);
    push_cmd(base + 'h20,   6'd1);
  endtask

  // Monitor: compare every FIFO push against the scoreboard.
  initial forever begin
    cmd_t c;
    logic [31:0] w;
    @(negedge clk);
    if (!reset) begin
      if (frame_done) n_done++;
      if (wr_en) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wr_unexpected: got data 'h%0h, expected no write", wr_data);
        end else begin
          w = exp_wr.pop_front();
          check("wr_data", 64'(wr_data), 64'(w));
          check("wr_mask", 64'(wr_mask), 64'(0));
        end
      end
      if (cmd_en) begin
        if (exp_cmd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cmd_unexpected: got addr 'h%0h bl %0d, expected no command",
                   cmd_byte_addr, cmd_bl);
        end else begin
          c = exp_cmd.pop_front();
          check("cmd_addr",  64'(cmd_byte_addr), 64'(c.addr));
          check("cmd_bl",    64'(cmd_bl), 64'(c.bl));
          check("cmd_instr", 64'(cmd_instr), 64'(0));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},      64'(in_ready), 64'(0));
    check({tag, "_wr_en"},         64'(wr_en), 64'(0));
    check({tag, "_cmd_en"},        64'(cmd_en), 64'(0));
    check({tag, "_frame_done"},    64'(frame_done), 64'(0));
    check({tag, "_busy"},          64'(busy), 64'(0));
    check({tag, "_wr_data"},       64'(wr_data), 64'(0));
    check({tag, "_cmd_bl"},        64'(cmd_bl), 64'(0));
    check({tag, "_cmd_addr"},      64'(cmd_byte_addr), 64'(0));
    check({tag, "_write_frame"},   64'(write_frame), 64'(0));
    check({tag, "_display_frame"}, 64'(display_frame), 64'(2));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; mem_calib_done = 1'b0; in_valid = 1'b0;
    clear_req = 1'b0; restart = 1'b0; wr_full = 1'b0; cmd_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 mem_calib_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 n_done = 0;
  endtask

  // Offer n consecutive words base+i; vmask gates in_valid cycle by cycle.
  task automatic send_words(input int n, input logic [31:0] base,
                            input logic [15:0] vmask, input string name);
    int   i = 0;
    int   cyc = 0;
    logic acc;
    for (int k = 0; k < n; k++) exp_wr.push_back(base + 32'(k));
    while (i < n && cyc < 500) begin
      in_valid = vmask[4'(cyc)];
      in_data  = base + 32'(i);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    if (i < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: accepted %0d words, expected %0d", name, i, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    @(negedge clk);
    while (busy && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, c);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_wr_left"},  64'(exp_wr.size()), 64'(0));
    check({tag, "_cmd_left"}, 64'(exp_cmd.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then WAIT_CAL holds off input until calibration.
    #12;
    check_reset_outputs("por");
    @(posedge clk); #1 reset = 1'b0;
    in_valid = 1'b1; in_data = 32'hBAD0_0000;
    repeat (3) begin
      @(negedge clk);
      check("wait_cal_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    mem_calib_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single frame of 10 words.
    push_frame_cmds('h100);
    send_words(10, 32'h1000_0000, 16'hFFFF, "t1_send");
    wait_idle("t1_idle");
    check("t1_frame_done", 64'(n_done), 64'(1));
    check("t1_write_frame", 64'(write_frame), 64'(1));
    check("t1_display_frame", 64'(display_frame), 64'(0));
    check_drained("t1");

    // 2: three frames, buffer index wraps.
    do_reset();
    push_frame_cmds('h100);
    push_frame_cmds('h140);
    push_frame_cmds('h180);
    send_words(30, 32'h2000_0000, 16'hFFFF, "t2_send");
    wait_idle("t2_idle");
    check("t2_frame_done", 64'(n_done), 64'(3));
    check("t2_write_frame", 64'(write_frame), 64'(0));
    check("t2_display_frame", 64'(display_frame), 64'(2));
    check_drained("t2");

    // 3: wr_full stall mid-burst with gappy in_valid.
    do_reset();
    push_frame_cmds('h100);
    fork
      send_words(10, 32'h3000_0000, 16'b1101_1011_0110_1110, "t3_send");
      begin
        repeat (3) @(posedge clk);
        #1 wr_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 wr_full = 1'b0;
      end
    join
    wait_idle("t3_idle");
    check("t3_frame_done", 64'(n_done), 64'(1));
    check_drained("t3");

    // 4: clear after 6 words.
    do_reset();
    push_cmd('h100, 6'd3);
    push_cmd('h110, 6'd1);
    push_frame_cmds('h100);
    send_words(6, 32'h4000_0000, 16'hFFFF, "t4_send");
    for (int k = 0; k < 10; k++) exp_wr.push_back(CLR);
    clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    wait_idle("t4_idle");
    @(negedge clk);
    check("t4_in_ready", 64'(in_ready), 64'(1));
    check("t4_frame_done", 64'(n_done), 64'(0));
    check("t4_write_frame", 64'(write_frame), 64'(0));
    check("t4_display_frame", 64'(display_frame), 64'(2));
    @(posedge clk); #1;
    check_drained("t4");

    // 5: restart after 5 words, then a full frame.
    do_reset();
    push_cmd('h100, 6'd3);
    push_cmd('h110, 6'd0);
    push_frame_cmds('h100);
    send_words(5, 32'h5000_0000, 16'hFFFF, "t5_send_a");
    restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    send_words(10, 32'h5100_0000, 16'hFFFF, "t5_send_b");
    wait_idle("t5_idle");
    check("t5_frame_done", 64'(n_done), 64'(1));
    check("t5_write_frame", 64'(write_frame), 64'(1));
    check_drained("t5");

    // 6: cmd_full hold at a burst boundary, then reset mid-burst.
    do_reset();
    push_cmd('h100, 6'd3);
    cmd_full = 1'b1;
    send_words(4, 32'h6000_0000, 16'hFFFF, "t6_send_a");
    in_valid = 1'b1;
    in_data  = 32'h6000_0004;
    repeat (8) begin
      @(negedge clk);
      check("t6_hold_in_ready", 64'(in_ready), 64'(0));
      check("t6_hold_cmd_en", 64'(cmd_en), 64'(0));
      check("t6_hold_addr", 64'(cmd_byte_addr), 64'('h100));
      check("t6_hold_bl", 64'(cmd_bl), 64'(3));
      @(posedge clk); #1;
    end
    cmd_full = 1'b0;
    send_words(2, 32'h6000_0004, 16'hFFFF, "t6_send_b");
    reset = 1'b1;
    mem_calib_done = 1'b0;
    #1;
    check_reset_outputs("mid");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hBAD0_0001;
    repeat (4) begin
      @(negedge clk);
      check("t6_wait_cal_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    mem_calib_done = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_ready_after_cal", 64'(in_ready), 64'(1));
    check_drained("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
